// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
package hazard_pkg;

    // Operand mux select encoding: input a = register file, b = WB, c = MEM.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // EX shadow keeps the source registers so the forward selects can be formed.
    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } ex_stage_t;

    // MEM shadow: mem_read blocks MEM->EX forwarding of a load.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } mem_stage_t;

    // WB shadow: by WB a load's data is the written result, so mem_read is not needed.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
    } wb_stage_t;

endpackage

// File: rtl/fwd_select.sv
// Select for one EX operand mux: MEM ALU result beats WB result beats register file.
module fwd_select
    import hazard_pkg::*;
(
    input  logic       ex_valid,
    input  logic [4:0] rs,
    input  logic       mem_valid,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic       mem_mem_read,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] sel
);

    // Priority select; x0 never forwards, an empty EX slot always reads the register file.
    always_comb begin
        sel = FWD_RF;
        if (ex_valid && (rs != 5'd0)) begin
            if (mem_valid && mem_reg_write && (mem_rd == rs) && !mem_mem_read) begin
                sel = FWD_MEM;
            end else if (wb_valid && wb_reg_write && (wb_rd == rs)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller: shadow EX/MEM/WB tracking, operand forward
// selects, load-use stall FSM and taken-branch flush.
// Handshake note: there is no valid/ready traffic here; mem_wait is a global
// freeze that holds all state, and stall/flush/bubble are same-cycle commands.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_reg_write,
    input  logic       id_mem_read,
    input  logic       ex_branch_taken,
    input  logic       mem_wait,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b,
    output logic       stall_pc,
    output logic       flush_if_id,
    output logic       bubble_ex
);

    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL_CYCLES - 1);

    ex_stage_t  ex_q,  ex_d;
    mem_stage_t mem_q, mem_d;
    wb_stage_t  wb_q,  wb_d;
    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic load_use;
    logic flush;

    assign flush    = ex_branch_taken && ex_q.valid;
    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && id_valid &&
                      ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_q.rd)));

    // Control FSM: freeze > flush > ongoing stall > new load-use hazard > normal.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_pc    = 1'b0;
        flush_if_id = 1'b0;
        bubble_ex   = 1'b0;
        if (mem_wait) begin
            state_d = state_q;
        end else if (flush) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
            state_d     = RUN;
            cnt_d       = 2'd0;
        end else if (state_q == STALL) begin
            stall_pc  = 1'b1;
            bubble_ex = 1'b1;
            cnt_d     = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
                state_d = RUN;
            end
        end else if (load_use) begin
            stall_pc  = 1'b1;
            bubble_ex = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_d = STALL;
                cnt_d   = STALL_RELOAD;
            end
        end
    end

    // Shadow pipeline advance; an inserted bubble enters EX as an invalid slot.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!mem_wait) begin
            wb_d.valid      = mem_q.valid;
            wb_d.rd         = mem_q.rd;
            wb_d.reg_write  = mem_q.reg_write;
            mem_d.valid     = ex_q.valid;
            mem_d.rd        = ex_q.rd;
            mem_d.reg_write = ex_q.reg_write;
            mem_d.mem_read  = ex_q.mem_read;
            ex_d.valid      = id_valid && !bubble_ex;
            ex_d.rs1        = id_rs1;
            ex_d.rs2        = id_rs2;
            ex_d.rd         = id_rd;
            ex_d.reg_write  = id_reg_write;
            ex_d.mem_read   = id_mem_read;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    fwd_select u_fwd_a (
        .ex_valid      (ex_q.valid),
        .rs            (ex_q.rs1),
        .mem_valid     (mem_q.valid),
        .mem_rd        (mem_q.rd),
        .mem_reg_write (mem_q.reg_write),
        .mem_mem_read  (mem_q.mem_read),
        .wb_valid      (wb_q.valid),
        .wb_rd         (wb_q.rd),
        .wb_reg_write  (wb_q.reg_write),
        .sel           (forward_a)
    );

    fwd_select u_fwd_b (
        .ex_valid      (ex_q.valid),
        .rs            (ex_q.rs2),
        .mem_valid     (mem_q.valid),
        .mem_rd        (mem_q.rd),
        .mem_reg_write (mem_q.reg_write),
        .mem_mem_read  (mem_q.mem_read),
        .wb_valid      (wb_q.valid),
        .wb_rd         (wb_q.rd),
        .wb_reg_write  (wb_q.reg_write),
        .sel           (forward_b)
    );

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench: u1 has a one-cycle load stall, u2 a two-cycle load stall.
module tb_hazard_forward_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       ex_branch_taken;
    logic       mem_wait;
    logic [1:0] fa1, fb1, fa2, fb2;
    logic       sp1, fl1, bx1, sp2, fl2, bx2;

    int checks = 0;
    int errors = 0;

    hazard_forward_ctrl #(.LOAD_STALL_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
        .forward_a(fa1), .forward_b(fb1), .stall_pc(sp1), .flush_if_id(fl1), .bubble_ex(bx1)
    );

    hazard_forward_ctrl #(.LOAD_STALL_CYCLES(2)) u2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
        .forward_a(fa2), .forward_b(fb2), .stall_pc(sp2), .flush_if_id(fl2), .bubble_ex(bx2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1b, input logic u2b, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = u1b;
        id_use_rs2   = u2b;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic id_nop;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset;
        rst             = 1'b1;
        ex_branch_taken = 1'b0;
        mem_wait        = 1'b0;
        id_nop();
        #4;
        rst = 1'b0;
        tick();
    endtask

    // Load x7 then a consumer reading x7 via rs2; ends in the first hazard cycle.
    task automatic load_then_consumer(input logic use2);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd7, 1'b1, use2, 5'd9, 1'b1, 1'b0);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ex_branch_taken = 1'b0;
        mem_wait = 1'b0;
        set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
        #2;
        checks++; if (fa1 !== 2'b00) begin errors++; $display("FAIL reset_fa got %b exp 00", fa1); end
        checks++; if (fb1 !== 2'b00) begin errors++; $display("FAIL reset_fb got %b exp 00", fb1); end
        checks++; if ({sp1, fl1, bx1} !== 3'b000) begin errors++; $display("FAIL reset_ctrl1 got %b exp 000", {sp1, fl1, bx1}); end
        checks++; if ({sp2, fl2, bx2} !== 3'b000) begin errors++; $display("FAIL reset_ctrl2 got %b exp 000", {sp2, fl2, bx2}); end
        do_reset();
    endtask

    task automatic test_fwd_mem;
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
        tick();
        set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);   // reads x5, x6
        #1;
        checks++; if (sp1 !== 1'b0) begin errors++; $display("FAIL alu_no_stall got %b exp 0", sp1); end
        tick();
        id_nop();
        #1;
        checks++; if (fa1 !== 2'b10) begin errors++; $display("FAIL fwd_a_mem got %b exp 10", fa1); end
        checks++; if (fb1 !== 2'b00) begin errors++; $display("FAIL fwd_b_rf got %b exp 00", fb1); end
    endtask

    task automatic test_fwd_priority;
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        #1;
        checks++; if (fb1 !== 2'b10) begin errors++; $display("FAIL fwd_b_mem_over_wb got %b exp 10", fb1); end
        tick();
        id_nop();
        #1;
        checks++; if (fb1 !== 2'b01) begin errors++; $display("FAIL fwd_b_wb got %b exp 01", fb1); end
    endtask

    task automatic test_fwd_x0_invalid;
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);   // writes x0
        tick();
        set_id(1'b1, 5'd0, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        id_nop();
        #1;
        checks++; if (fa1 !== 2'b00) begin errors++; $display("FAIL fwd_x0 got %b exp 00", fa1); end
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);   // invalid slot reading x5
        tick();
        id_nop();
        #1;
        checks++; if ({fa1, fb1} !== 4'b0000) begin errors++; $display("FAIL fwd_ex_invalid got %b exp 0000", {fa1, fb1}); end
    endtask

    task automatic test_load_use_n1;
        do_reset();
        load_then_consumer(1'b1);
        checks++; if ({sp1, bx1, fl1} !== 3'b110) begin errors++; $display("FAIL n1_stall got %b exp 110", {sp1, bx1, fl1}); end
        tick();
        #1;
        checks++; if ({sp1, bx1} !== 2'b00) begin errors++; $display("FAIL n1_release got %b exp 00", {sp1, bx1}); end
        tick();
        id_nop();
        #1;
        checks++; if (fb1 !== 2'b01) begin errors++; $display("FAIL n1_fwd_b_wb got %b exp 01", fb1); end
        checks++; if (fa1 !== 2'b00) begin errors++; $display("FAIL n1_fwd_a_rf got %b exp 00", fa1); end
        do_reset();
        load_then_consumer(1'b0);
        checks++; if ({sp1, bx1} !== 2'b00) begin errors++; $display("FAIL n1_unused_src got %b exp 00", {sp1, bx1}); end
    endtask

    task automatic test_load_use_n2;
        do_reset();
        load_then_consumer(1'b1);
        checks++; if ({sp2, bx2} !== 2'b11) begin errors++; $display("FAIL n2_stall1 got %b exp 11", {sp2, bx2}); end
        tick();
        #1;
        checks++; if ({sp2, bx2} !== 2'b11) begin errors++; $display("FAIL n2_stall2 got %b exp 11", {sp2, bx2}); end
        tick();
        #1;
        checks++; if ({sp2, bx2} !== 2'b00) begin errors++; $display("FAIL n2_release got %b exp 00", {sp2, bx2}); end
    endtask

    task automatic test_flush;
        // Taken branch with a valid EX overrides the load-use hazard.
        do_reset();
        load_then_consumer(1'b1);
        ex_branch_taken = 1'b1;
        #1;
        checks++; if ({fl2, sp2, bx2} !== 3'b101) begin errors++; $display("FAIL flush_over_hazard got %b exp 101", {fl2, sp2, bx2}); end
        tick();
        ex_branch_taken = 1'b0;
        #1;
        checks++; if ({fl2, sp2, bx2} !== 3'b000) begin errors++; $display("FAIL flush_then_run got %b exp 000", {fl2, sp2, bx2}); end
        // In the second stall cycle EX holds a bubble, so a branch signal cannot flush.
        do_reset();
        load_then_consumer(1'b1);
        tick();
        ex_branch_taken = 1'b1;
        #1;
        checks++; if ({fl2, sp2} !== 2'b01) begin errors++; $display("FAIL branch_on_bubble got %b exp 01", {fl2, sp2}); end
        tick();
        ex_branch_taken = 1'b0;
        #1;
        checks++; if (sp2 !== 1'b0) begin errors++; $display("FAIL branch_on_bubble_end got %b exp 0", sp2); end
    endtask

    task automatic test_mem_wait;
        // Freeze in the middle of the two-cycle stall.
        do_reset();
        load_then_consumer(1'b1);
        tick();
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({sp2, bx2, fl2} !== 3'b000) begin errors++; $display("FAIL wait_ctrl_%0d got %b exp 000", i, {sp2, bx2, fl2}); end
            tick();
        end
        mem_wait = 1'b0;
        #1;
        checks++; if ({sp2, bx2} !== 2'b11) begin errors++; $display("FAIL wait_resume got %b exp 11", {sp2, bx2}); end
        tick();
        #1;
        checks++; if (sp2 !== 1'b0) begin errors++; $display("FAIL wait_resume_end got %b exp 0", sp2); end
        // Forward selects hold while frozen.
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        id_nop();
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (fa1 !== 2'b10) begin errors++; $display("FAIL wait_fwd_hold_%0d got %b exp 10", i, fa1); end
            tick();
        end
        mem_wait = 1'b0;
        tick();
        #1;
        checks++; if (fa1 !== 2'b00) begin errors++; $display("FAIL wait_fwd_advance got %b exp 00", fa1); end
    endtask

    task automatic test_reset_mid_stall;
        do_reset();
        load_then_consumer(1'b1);
        tick();
        #1;
        checks++; if (sp2 !== 1'b1) begin errors++; $display("FAIL pre_reset_stall got %b exp 1", sp2); end
        rst = 1'b1;
        #1;
        checks++; if ({fa2, fb2, sp2, fl2, bx2} !== 7'b0) begin errors++; $display("FAIL mid_stall_reset got %b exp 0000000", {fa2, fb2, sp2, fl2, bx2}); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        #1;
        checks++; if ({sp2, bx2} !== 2'b00) begin errors++; $display("FAIL after_reset_run got %b exp 00", {sp2, bx2}); end
    endtask

    initial begin
        test_reset();
        test_fwd_mem();
        test_fwd_priority();
        test_fwd_x0_invalid();
        test_load_use_n1();
        test_load_use_n2();
        test_flush();
        test_mem_wait();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
